// File: rtl/yapp_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : yapp_input_arbiter
// Description : Packet-level round-robin arbiter that merges NUM_SRC YAPP
//               sources onto the single router input port.
// Revision    : 1.0 - initial release
// ============================================================================
module yapp_input_arbiter #(
    parameter int NUM_SRC     = 3,
    parameter int STALL_LIMIT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_vld,
    output logic [NUM_SRC-1:0]   src_suspend,
    input  logic [NUM_SRC-1:0]   src_enable,
    output logic [7:0]           in_data,
    output logic                 in_data_vld,
    input  logic                 in_suspend,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 pkt_done,
    output logic                 pkt_abort
);

    localparam int c_IW = $clog2(NUM_SRC);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [c_IW-1:0] gidx_q, gidx_d;
    logic [c_IW-1:0] last_q, last_d;
    logic            first_q, first_d;
    logic [6:0]      rem_q, rem_d;
    logic [7:0]      stall_q, stall_d;
    logic            done_q, done_d;
    logic            abort_q, abort_d;

    logic [NUM_SRC-1:0] w_cand;
    logic               w_found;
    logic [c_IW-1:0]    w_pick;
    logic [7:0]         w_sel_data;
    logic               w_sel_vld;
    logic               w_accept;

    assign w_cand     = src_vld & src_enable;
    assign w_sel_data = src_data[8*int'(gidx_q) +: 8];
    assign w_sel_vld  = src_vld[gidx_q];
    assign pkt_done   = done_q;
    assign pkt_abort  = abort_q;

    // First candidate searching upward from the source after last_grant.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_q) + k) % NUM_SRC;
            if (!w_found && w_cand[idx]) begin
                w_found = 1'b1;
                w_pick  = c_IW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        first_d     = first_q;
        rem_d       = rem_q;
        stall_d     = stall_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        in_data     = '0;
        in_data_vld = 1'b0;
        src_suspend = '1;
        grant       = '0;
        w_accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    state_d = S_XFER;
                    gidx_d  = w_pick;
                    last_d  = w_pick;
                    first_d = 1'b1;
                    stall_d = '0;
                end
            end
            S_XFER: begin
                in_data             = w_sel_data;
                in_data_vld         = w_sel_vld;
                src_suspend[gidx_q] = in_suspend;
                grant[gidx_q]       = 1'b1;
                w_accept            = w_sel_vld && !in_suspend;
                if (first_q) begin
                    // A source that withdraws before its header is simply released.
                    if (!w_sel_vld) begin
                        state_d = S_IDLE;
                    end else if (w_accept) begin
                        rem_d   = {1'b0, w_sel_data[7:2]} + 7'd1;
                        first_d = 1'b0;
                    end
                end else begin
                    if (w_accept) begin
                        if (rem_q == 7'd1) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            rem_d = rem_q - 7'd1;
                        end
                    end
                    if (w_sel_vld) begin
                        stall_d = '0;
                    end else if (!in_suspend) begin
                        stall_d = stall_q + 8'd1;
                        if (stall_d == 8'(STALL_LIMIT)) begin
                            abort_d = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            gidx_q  <= '0;
            last_q  <= c_IW'(NUM_SRC - 1);
            first_q <= 1'b0;
            rem_q   <= '0;
            stall_q <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            first_q <= first_d;
            rem_q   <= rem_d;
            stall_q <= stall_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_yapp_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_yapp_input_arbiter
// Description : Directed self-checking bench for yapp_input_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_yapp_input_arbiter;

    localparam int NUM_SRC     = 3;
    localparam int STALL_LIMIT = 16;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_vld;
    logic [NUM_SRC-1:0]   src_suspend;
    logic [NUM_SRC-1:0]   src_enable;
    logic [7:0]           in_data;
    logic                 in_data_vld;
    logic                 in_suspend;
    logic [NUM_SRC-1:0]   grant;
    logic                 pkt_done;
    logic                 pkt_abort;

    yapp_input_arbiter #(.NUM_SRC(NUM_SRC), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clock(clock), .reset(reset), .src_data(src_data), .src_vld(src_vld),
        .src_suspend(src_suspend), .src_enable(src_enable), .in_data(in_data),
        .in_data_vld(in_data_vld), .in_suspend(in_suspend), .grant(grant),
        .pkt_done(pkt_done), .pkt_abort(pkt_abort)
    );

    always #5 clock = ~clock;

    logic [7:0]         srcq [NUM_SRC][$];
    logic [7:0]         xs   [NUM_SRC][$];
    logic [NUM_SRC-1:0] hold;

    logic               lg_vld   [512];
    logic [7:0]         lg_data  [512];
    logic [NUM_SRC-1:0] lg_grant [512];
    logic [NUM_SRC-1:0] lg_ssus  [512];
    logic               lg_done  [512];
    logic               lg_abort [512];
    int n, total, bad;

    task automatic drive();
        for (int i = 0; i < NUM_SRC; i++) begin
            src_vld[i]         = (srcq[i].size() > 0) && !hold[i];
            src_data[8*i +: 8] = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
        end
    endtask

    // One clock: drive sources, log outputs mid-cycle, pop accepted bytes.
    task automatic tick();
        logic [NUM_SRC-1:0] acc;
        drive();
        @(negedge clock);
        lg_vld[n]   = in_data_vld;
        lg_data[n]  = in_data;
        lg_grant[n] = grant;
        lg_ssus[n]  = src_suspend;
        lg_done[n]  = pkt_done;
        lg_abort[n] = pkt_abort;
        for (int i = 0; i < NUM_SRC; i++) begin
            acc[i] = src_vld[i] && !src_suspend[i];
            if (grant[i] && in_data_vld && !in_suspend) xs[i].push_back(in_data);
        end
        if (n < 511) n++;
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM_SRC; i++) if (acc[i]) void'(srcq[i].pop_front());
    endtask

    task automatic start_test();
        n = 0;
        for (int i = 0; i < NUM_SRC; i++) xs[i].delete();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; src_enable = '1; in_suspend = 1'b0; hold = '0;
        tick(); tick();
        reset = 1'b0;
        start_test();
        tick();
        total++; if (lg_vld[0] !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b want=0", lg_vld[0]); end
        total++; if (lg_data[0] !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h want=00", lg_data[0]); end
        total++; if (lg_ssus[0] !== 3'b111) begin bad++; $display("FAIL reset_ssus got=%0b want=111", lg_ssus[0]); end
        total++; if (lg_grant[0] !== 3'b000) begin bad++; $display("FAIL reset_grant got=%0b want=000", lg_grant[0]); end
        total++; if ({lg_done[0], lg_abort[0]} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%0b want=00", {lg_done[0], lg_abort[0]}); end
    endtask

    task automatic test_single();
        logic [7:0] ev;
        logic [7:0] eb [5];
        ev = 8'b0011_1110;
        eb = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        start_test();
        for (int k = 0; k < 5; k++) srcq[0].push_back(eb[k]);
        for (int t = 0; t < 8; t++) tick();
        for (int t = 0; t < 8; t++) begin
            total++; if (lg_vld[t] !== ev[t]) begin bad++; $display("FAIL single_vld t=%0d got=%0b want=%0b", t, lg_vld[t], ev[t]); end
            total++; if (lg_done[t] !== (t == 6)) begin bad++; $display("FAIL single_done t=%0d got=%0b want=%0b", t, lg_done[t], t == 6); end
        end
        for (int t = 1; t < 6; t++) begin
            total++; if (lg_grant[t] !== 3'b001) begin bad++; $display("FAIL single_grant t=%0d got=%0b want=001", t, lg_grant[t]); end
        end
        total++; if (lg_grant[6] !== 3'b000) begin bad++; $display("FAIL single_grant_idle got=%0b want=000", lg_grant[6]); end
        total++; if (xs[0].size() !== 5) begin bad++; $display("FAIL single_count got=%0d want=5", xs[0].size()); end
        else for (int k = 0; k < 5; k++) begin
            total++; if (xs[0][k] !== eb[k]) begin bad++; $display("FAIL single_byte k=%0d got=%0h want=%0h", k, xs[0][k], eb[k]); end
        end
    endtask

    task automatic test_round_robin();
        logic               ev;
        logic [NUM_SRC-1:0] eg;
        pulse_reset();
        start_test();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_SRC; i++) begin
                srcq[i].push_back(8'h00);
                srcq[i].push_back(8'hA0 + 8'(i));
            end
        for (int t = 0; t < 20; t++) tick();
        // Three-cycle slots: arbitration/idle, header, parity.
        for (int t = 0; t < 19; t++) begin
            ev = (t % 3) != 0;
            eg = ev ? NUM_SRC'(1 << ((t / 3) % 3)) : '0;
            total++; if (lg_vld[t] !== ev) begin bad++; $display("FAIL rr_vld t=%0d got=%0b want=%0b", t, lg_vld[t], ev); end
            total++; if (lg_grant[t] !== eg) begin bad++; $display("FAIL rr_grant t=%0d got=%0b want=%0b", t, lg_grant[t], eg); end
            total++; if (lg_done[t] !== (t > 0 && t % 3 == 0)) begin bad++; $display("FAIL rr_done t=%0d got=%0b", t, lg_done[t]); end
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] eb [6];
        int dones;
        eb = '{8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h14};
        start_test();
        for (int k = 0; k < 6; k++) srcq[0].push_back(eb[k]);
        tick(); tick(); tick();
        in_suspend = 1'b1;
        for (int t = 3; t < 7; t++) begin
            tick();
            total++; if (dut.stall_q !== 8'd0) begin bad++; $display("FAIL bp_stall t=%0d got=%0d want=0", t, dut.stall_q); end
        end
        in_suspend = 1'b0;
        for (int t = 7; t < 13; t++) tick();
        for (int t = 3; t < 7; t++) begin
            total++; if (lg_ssus[t] !== 3'b111) begin bad++; $display("FAIL bp_ssus t=%0d got=%0b want=111", t, lg_ssus[t]); end
            total++; if ({lg_vld[t], lg_data[t]} !== {1'b1, 8'h02}) begin bad++; $display("FAIL bp_hold t=%0d got=%0b/%0h want=1/02", t, lg_vld[t], lg_data[t]); end
        end
        total++; if (lg_ssus[7] !== 3'b110) begin bad++; $display("FAIL bp_release got=%0b want=110", lg_ssus[7]); end
        dones = 0;
        for (int t = 0; t < 13; t++) dones += int'(lg_done[t]);
        total++; if (dones !== 1 || lg_done[11] !== 1'b1) begin bad++; $display("FAIL bp_done got=%0d/%0b want=1/1", dones, lg_done[11]); end
        total++; if (xs[0].size() !== 6) begin bad++; $display("FAIL bp_count got=%0d want=6", xs[0].size()); end
        else for (int k = 0; k < 6; k++) begin
            total++; if (xs[0][k] !== eb[k]) begin bad++; $display("FAIL bp_byte k=%0d got=%0h want=%0h", k, xs[0][k], eb[k]); end
        end
    endtask

    task automatic test_stall_abort();
        int aborts;
        start_test();
        srcq[1].push_back(8'h28);
        for (int k = 1; k <= 11; k++) srcq[1].push_back(8'(k));
        srcq[2].push_back(8'h00);
        srcq[2].push_back(8'h55);
        tick(); tick(); tick();
        hold[1] = 1'b1;
        for (int t = 3; t < 25; t++) tick();
        total++; if (lg_grant[1] !== 3'b010) begin bad++; $display("FAIL stall_first got=%0b want=010", lg_grant[1]); end
        total++; if ({lg_vld[3], lg_grant[3]} !== 4'b0010) begin bad++; $display("FAIL stall_start got=%0b/%0b want=0/010", lg_vld[3], lg_grant[3]); end
        total++; if ({lg_grant[18], lg_abort[18]} !== 4'b0100) begin bad++; $display("FAIL stall_early got=%0b/%0b want=010/0", lg_grant[18], lg_abort[18]); end
        total++; if ({lg_abort[19], lg_grant[19]} !== 4'b1000) begin bad++; $display("FAIL stall_abort got=%0b/%0b want=1/000", lg_abort[19], lg_grant[19]); end
        total++; if ({lg_vld[20], lg_grant[20]} !== 4'b1100) begin bad++; $display("FAIL stall_next got=%0b/%0b want=1/100", lg_vld[20], lg_grant[20]); end
        aborts = 0;
        for (int t = 0; t < 25; t++) aborts += int'(lg_abort[t]);
        total++; if (aborts !== 1) begin bad++; $display("FAIL stall_abort_count got=%0d want=1", aborts); end
        total++; if (lg_done[22] !== 1'b1) begin bad++; $display("FAIL stall_next_done got=%0b want=1", lg_done[22]); end
        srcq[1].delete();
        hold[1] = 1'b0;
    endtask

    task automatic test_mask_boundary();
        logic [7:0] eb [$];
        int g1, dones;
        start_test();
        src_enable = 3'b101;
        eb.push_back(8'hFC);
        for (int k = 1; k <= 63; k++) eb.push_back(8'(k));
        eb.push_back(8'h5A);
        foreach (eb[k]) srcq[0].push_back(eb[k]);
        srcq[1].push_back(8'h00); srcq[1].push_back(8'h11);
        srcq[2].push_back(8'h00); srcq[2].push_back(8'h22);
        for (int t = 0; t < 75; t++) tick();
        g1 = 0; dones = 0;
        for (int t = 0; t < 75; t++) begin
            g1    += int'(lg_grant[t][1]);
            dones += int'(lg_done[t]);
        end
        total++; if (g1 !== 0) begin bad++; $display("FAIL mask_src1 got=%0d want=0", g1); end
        total++; if (srcq[1].size() !== 2) begin bad++; $display("FAIL mask_src1_q got=%0d want=2", srcq[1].size()); end
        total++; if (lg_done[66] !== 1'b1) begin bad++; $display("FAIL mask_done65 got=%0b want=1", lg_done[66]); end
        total++; if (lg_grant[67] !== 3'b100) begin bad++; $display("FAIL mask_next got=%0b want=100", lg_grant[67]); end
        total++; if (dones !== 2) begin bad++; $display("FAIL mask_done_count got=%0d want=2", dones); end
        total++; if (xs[0].size() !== 65) begin bad++; $display("FAIL mask_count got=%0d want=65", xs[0].size()); end
        else for (int k = 0; k < 65; k++) begin
            total++; if (xs[0][k] !== eb[k]) begin bad++; $display("FAIL mask_byte k=%0d got=%0h want=%0h", k, xs[0][k], eb[k]); end
        end
        srcq[1].delete();
        src_enable = '1;
    endtask

    task automatic test_reset_mid();
        start_test();
        srcq[1].push_back(8'h0C);
        for (int k = 1; k <= 4; k++) srcq[1].push_back(8'(k));
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        srcq[0].push_back(8'h00);
        srcq[0].push_back(8'h77);
        for (int t = 4; t < 9; t++) tick();
        total++; if ({lg_vld[3], lg_grant[3]} !== 4'b1010) begin bad++; $display("FAIL rmid_busy got=%0b/%0b want=1/010", lg_vld[3], lg_grant[3]); end
        total++; if (lg_vld[4] !== 1'b0) begin bad++; $display("FAIL rmid_vld got=%0b want=0", lg_vld[4]); end
        total++; if (lg_ssus[4] !== 3'b111) begin bad++; $display("FAIL rmid_ssus got=%0b want=111", lg_ssus[4]); end
        total++; if ({lg_grant[4], lg_abort[4]} !== 4'b0000) begin bad++; $display("FAIL rmid_idle got=%0b/%0b want=000/0", lg_grant[4], lg_abort[4]); end
        total++; if (lg_grant[5] !== 3'b001) begin bad++; $display("FAIL rmid_prio got=%0b want=001", lg_grant[5]); end
        srcq[1].delete();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n     = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_stall_abort();
        test_mask_boundary();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/yapp_input_arbiter.md
# yapp_input_arbiter

Round-robin arbiter that shares the single YAPP input port of `yapp_router` among `NUM_SRC` independent YAPP packet sources. It sits in `hw_top` between the sources and the router's `in_data`/`in_data_vld`/`in_suspend` pins. It grants whole packets only and tracks YAPP framing (header, payload, parity) to find packet ends. It inserts the mandatory idle cycle between packets and abandons a packet whose source stalls too long.

## Interface

- `NUM_SRC`, 3: number of requesting sources (2..4).
- `STALL_LIMIT`, 16: consecutive mid-packet cycles with granted `src_vld` low before the packet is abandoned (1..255).
- `clock`  in  1  single clock for the block.
- `reset`  in  1  synchronous, active-high reset.
- `src_data`  in  8*NUM_SRC  byte from source i on bits [8i+7:8i].
- `src_vld`  in  NUM_SRC  source i has a valid byte.
- `src_suspend`  out  NUM_SRC  hold request to source i; its byte is accepted only when `src_vld[i]`=1 and `src_suspend[i]`=0.
- `src_enable`  in  NUM_SRC  source i may be granted; sampled only at arbitration.
- `in_data`  out  8  byte to router.
- `in_data_vld`  out  1  byte valid to router.
- `in_suspend`  in  1  router back-pressure.
- `grant`  out  NUM_SRC  one-hot owner of the current packet; 0 when idle.
- `pkt_done`  out  1  one-cycle pulse when a packet's parity byte is accepted.
- `pkt_abort`  out  1  one-cycle pulse when a packet is abandoned on stall.

## Operation

- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- YAPP framing:
  - The header byte carries `length`=data[7:2] and `addr`=data[1:0].
  - The header is followed by `length` payload bytes and 1 parity byte.
  - Total packet size is `length`+2 bytes, from 2 to 65.
- Transfer rule: a byte transfers on any cycle where `in_data_vld`=1 and `in_suspend`=0.
- States: IDLE and XFER.
- IDLE:
  - `in_data_vld`=0, all `src_suspend`=1, `grant`=0.
  - Candidates are sources with `src_vld[i]`=1 and `src_enable[i]`=1.
  - If any candidate exists, register the grant as the first candidate searching upward (mod `NUM_SRC`) from `last_grant`+1. Update `last_grant`, clear `first`=1 and `stall_cnt`=0, and go to XFER.
  - Otherwise stay in IDLE.
- XFER, with g the granted source:
  - Datapath is combinational: `in_data`=`src_data[g]`, `in_data_vld`=`src_vld[g]`, `src_suspend[g]`=`in_suspend`.
  - All other `src_suspend` are 1.
- XFER byte accounting (7-bit `remaining`):
  - On an accepted byte with `first`=1: `remaining`←data[7:2]+1 and `first`←0.
  - On an accepted non-first byte: `remaining` decrements.
  - When an accepted non-first byte has `remaining`=1, pulse `pkt_done` and go to IDLE.
- Stall watchdog (8-bit `stall_cnt`):
  - Increments each XFER cycle with `src_vld[g]`=0 after the header is accepted, and clears on any cycle with `src_vld[g]`=1.
  - Cycles with `in_suspend`=1 never count as stall.
  - When `stall_cnt` reaches `STALL_LIMIT`, pulse `pkt_abort` and go to IDLE.
  - Before the header is accepted, a dropped `src_vld[g]` also returns to IDLE without an abort pulse.
- Changes to `src_enable` during XFER do not affect the current packet.
- Reset:
  - Outputs: `in_data`=0, `in_data_vld`=0, `src_suspend`=all ones, `grant`=0, `pkt_done`=0, `pkt_abort`=0.
  - Internal state: IDLE, `last_grant`=`NUM_SRC`-1 (so source 0 has first priority), counters cleared.
- Reset mid-packet: the packet is dropped and `in_data_vld` is 0 from the next edge. No `pkt_abort` pulse.

## Timing

- Arbitration takes one cycle. A packet's first byte can appear in the cycle after IDLE sees a candidate.
- The data path has zero latency, combinational from `src_*` to `in_*` and from `in_suspend` to `src_suspend`.
- Exactly one IDLE cycle (`in_data_vld`=0) separates back-to-back packets. This is the minimum inter-packet gap the router needs to detect a new header.
- `pkt_done` and `pkt_abort` are registered and assert in the cycle after the triggering condition, coincident with the IDLE cycle.
- Sustained throughput is `length`+2 bytes per `length`+3 cycles with no suspend.

## Test plan

- Single-source packets:
  - Stimulus: source 0 sends a header 0x0D (length 3, addr 1), 3 payload bytes, and parity, with no suspend.
  - Required response: 5 consecutive `in_data_vld` cycles, then `pkt_done` pulses once, then `grant`=0.
- Round-robin fairness:
  - Stimulus: all 3 sources hold 2-byte packets (header 0x00 + parity) continuously.
  - Required response: grant order is 0,1,2,0,1,2, with exactly 1 idle cycle between packets.
- Back-pressure:
  - Stimulus: `in_suspend`=1 for 4 cycles in mid-payload.
  - Required response: `src_suspend[g]` follows `in_suspend`, no byte is lost or duplicated, `stall_cnt` stays 0, and the parity byte is delivered intact.
- Stall abort:
  - Stimulus: with `STALL_LIMIT`=16, the granted source drops `src_vld` after 2 bytes of a length-10 packet.
  - Required response: `pkt_abort` pulses after 16 stall cycles and the next source is granted.
- Masking and boundary:
  - Stimulus: `src_enable`=3'b101 with all sources requesting, plus a length-63 header 0xFC.
  - Required response: source 1 is never granted, and the 65-byte packet completes with `pkt_done`.
- Reset mid-packet:
  - Stimulus: assert `reset` for 1 cycle during byte 3.
  - Required response: `in_data_vld`=0 and `src_suspend`=all ones on the next edge, and after release source 0 wins first.
